// File: rtl/a5_keystream_gen_pkg.sv
// a5_keystream_gen_pkg
// Shared defaults for the A5/1-style keystream generator: register widths,
// feedback tap masks, clocking-bit indices, run lengths, FSM state encoding
// and the majority helper used for irregular clocking.
package a5_keystream_gen_pkg;

  localparam int             DEF_R1_BITS = 19;
  localparam logic [18:0]    DEF_R1_TAPS = 19'h72000;
  localparam int             DEF_R1_CLK  = 8;
  localparam int             DEF_R2_BITS = 22;
  localparam logic [21:0]    DEF_R2_TAPS = 22'h300000;
  localparam int             DEF_R2_CLK  = 10;
  localparam int             DEF_R3_BITS = 23;
  localparam logic [22:0]    DEF_R3_TAPS = 23'h700080;
  localparam int             DEF_R3_CLK  = 10;

  localparam int DEF_KEY_BITS   = 64;
  localparam int DEF_FRAME_BITS = 22;
  localparam int DEF_WARMUP     = 100;
  localparam int DEF_KS_BITS    = 228;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_KEY   = 3'd1,
    ST_FRAME = 3'd2,
    ST_WARM  = 3'd3,
    ST_KS    = 3'd4
  } a5_state_t;

  // Majority of three clocking bits.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/a5_keystream_gen_if.sv
// a5_keystream_gen_if
// Bundles the control/data inputs and the keystream valid/ready handshake.
//   master : front-end/consumer side (drives start, key, frame, ks_ready[, abort])
//   slave  : generator side (drives busy, ks_bit, ks_valid, done)
// Optional macro A5_ABORT_EN adds the abort signal.
interface a5_keystream_gen_if
  import a5_keystream_gen_pkg::*;
#(
  parameter int KEY_BITS   = DEF_KEY_BITS,
  parameter int FRAME_BITS = DEF_FRAME_BITS
);
  logic                  start;
  logic [KEY_BITS-1:0]   key;
  logic [FRAME_BITS-1:0] frame;
  logic                  busy;
  logic                  ks_bit;
  logic                  ks_valid;
  logic                  ks_ready;
  logic                  done;
`ifdef A5_ABORT_EN
  logic                  abort;

  modport master (output start, key, frame, ks_ready, abort,
                  input  busy, ks_bit, ks_valid, done);
  modport slave  (input  start, key, frame, ks_ready, abort,
                  output busy, ks_bit, ks_valid, done);
`else
  modport master (output start, key, frame, ks_ready,
                  input  busy, ks_bit, ks_valid, done);
  modport slave  (input  start, key, frame, ks_ready,
                  output busy, ks_bit, ks_valid, done);
`endif
endinterface

// File: rtl/a5_keystream_gen_lfsr_stage.sv
// a5_lfsr_stage
// One clock-controlled LFSR stage. Shifts left; the new LSB is the XOR of
// the tapped bits with d.
//   clk, reset : clock, async active-high reset (state zero)
//   load       : synchronous clear of the whole register
//   clk_en     : step this cycle
//   d          : bit mixed into the feedback
//   q          : current MSB (stage output)
//   q_pre      : bit that becomes the MSB if the stage steps
//   clk_bit_o  : clocking bit for majority voting
module a5_lfsr_stage #(
  parameter int              BITS = 19,
  parameter logic [BITS-1:0] TAPS = 19'h72000,
  parameter int              CLK  = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic clk_en,
  input  logic d,
  output logic q,
  output logic q_pre,
  output logic clk_bit_o
);
  logic [BITS-1:0] state;
  logic            fb;

  assign fb        = (^(state & TAPS)) ^ d;
  assign q         = state[BITS-1];
  assign q_pre     = state[BITS-2];
  assign clk_bit_o = state[CLK];

  // Register update: clear has priority over stepping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= '0;
    end else if (load) begin
      state <= '0;
    end else if (clk_en) begin
      state <= {state[BITS-2:0], fb};
    end else begin
      state <= state;
    end
  end
endmodule

// File: rtl/a5_keystream_gen.sv
// a5_keystream_gen
// A5/1-style keystream generator: three majority-clocked LFSR stages and a
// sequencer (IDLE -> KEY -> FRAME -> WARM -> KS) that emits KS_BITS bits over
// a valid/ready handshake.
//   clk, reset : clock, async active-high reset
//   bus        : a5_keystream_gen_if.slave (start, key, frame, busy,
//                ks_bit, ks_valid, ks_ready, done[, abort])
// Optional macro A5_ABORT_EN: abort input returns to IDLE from any active state.
module a5_keystream_gen
  import a5_keystream_gen_pkg::*;
#(
  parameter int                 R1_BITS    = DEF_R1_BITS,
  parameter logic [R1_BITS-1:0] R1_TAPS    = DEF_R1_TAPS,
  parameter int                 R1_CLK     = DEF_R1_CLK,
  parameter int                 R2_BITS    = DEF_R2_BITS,
  parameter logic [R2_BITS-1:0] R2_TAPS    = DEF_R2_TAPS,
  parameter int                 R2_CLK     = DEF_R2_CLK,
  parameter int                 R3_BITS    = DEF_R3_BITS,
  parameter logic [R3_BITS-1:0] R3_TAPS    = DEF_R3_TAPS,
  parameter int                 R3_CLK     = DEF_R3_CLK,
  parameter int                 KEY_BITS   = DEF_KEY_BITS,
  parameter int                 FRAME_BITS = DEF_FRAME_BITS,
  parameter int                 WARMUP     = DEF_WARMUP,
  parameter int                 KS_BITS    = DEF_KS_BITS
) (
  input logic               clk,
  input logic               reset,
  a5_keystream_gen_if.slave bus
);
  localparam int MAX_A   = (KEY_BITS > FRAME_BITS) ? KEY_BITS : FRAME_BITS;
  localparam int MAX_B   = (WARMUP > KS_BITS) ? WARMUP : KS_BITS;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]      KEY_LAST   = CNT_W'(KEY_BITS - 1);
  localparam logic [CNT_W-1:0]      FRAME_LAST = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0]      WARM_LAST  = CNT_W'(WARMUP - 1);
  localparam logic [CNT_W-1:0]      KS_LAST    = CNT_W'(KS_BITS - 1);
  localparam logic [KEY_BITS-1:0]   KEY_ONE    = KEY_BITS'(1);
  localparam logic [FRAME_BITS-1:0] FRAME_ONE  = FRAME_BITS'(1);

  a5_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic             busy, ks_bit, ks_valid, done;

  logic       lfsr_load, din, maj, hs, final_hs, abort_hit, ks_next;
  logic [2:0] en, cbit, q, q_pre;

`ifdef A5_ABORT_EN
  assign abort_hit = bus.abort && (state != ST_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  assign maj      = maj3(cbit[0], cbit[1], cbit[2]);
  assign hs       = ks_valid && bus.ks_ready;
  assign final_hs = hs && (cnt == KS_LAST);
  // Post-step MSB of each stage: the shifted-in bit if it steps, else unchanged.
  assign ks_next  = (en[0] ? q_pre[0] : q[0]) ^ (en[1] ? q_pre[1] : q[1]) ^
                    (en[2] ? q_pre[2] : q[2]);

  // Stage control: clear, step enables and the mixed-in data bit per state.
  always_comb begin
    lfsr_load = 1'b0;
    en        = 3'b000;
    din       = 1'b0;
    if (abort_hit) begin
      lfsr_load = 1'b1;
    end else begin
      case (state)
        ST_IDLE:  lfsr_load = bus.start;
        ST_KEY: begin
          en  = 3'b111;
          din = |(bus.key & (KEY_ONE << cnt));
        end
        ST_FRAME: begin
          en  = 3'b111;
          din = |(bus.frame & (FRAME_ONE << cnt));
        end
        ST_WARM:  en = {cbit[2] == maj, cbit[1] == maj, cbit[0] == maj};
        ST_KS: begin
          if ((!ks_valid || bus.ks_ready) && !final_hs) begin
            en = {cbit[2] == maj, cbit[1] == maj, cbit[0] == maj};
          end else begin
            en = 3'b000;
          end
        end
        default:  lfsr_load = 1'b0;
      endcase
    end
  end

  a5_lfsr_stage #(.BITS(R1_BITS), .TAPS(R1_TAPS), .CLK(R1_CLK)) u_r1 (
    .clk(clk), .reset(reset), .load(lfsr_load), .clk_en(en[0]), .d(din),
    .q(q[0]), .q_pre(q_pre[0]), .clk_bit_o(cbit[0]));
  a5_lfsr_stage #(.BITS(R2_BITS), .TAPS(R2_TAPS), .CLK(R2_CLK)) u_r2 (
    .clk(clk), .reset(reset), .load(lfsr_load), .clk_en(en[1]), .d(din),
    .q(q[1]), .q_pre(q_pre[1]), .clk_bit_o(cbit[1]));
  a5_lfsr_stage #(.BITS(R3_BITS), .TAPS(R3_TAPS), .CLK(R3_CLK)) u_r3 (
    .clk(clk), .reset(reset), .load(lfsr_load), .clk_en(en[2]), .d(din),
    .q(q[2]), .q_pre(q_pre[2]), .clk_bit_o(cbit[2]));

  // Sequencer: state, phase counter and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      ks_bit   <= 1'b0;
      ks_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort_hit) begin
        state    <= ST_IDLE;
        cnt      <= '0;
        busy     <= 1'b0;
        ks_valid <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.start) begin
              state <= ST_KEY;
              cnt   <= '0;
              busy  <= 1'b1;
            end
          end
          ST_KEY: begin
            if (cnt == KEY_LAST) begin
              state <= ST_FRAME;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          ST_FRAME: begin
            if (cnt == FRAME_LAST) begin
              state <= ST_WARM;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          ST_WARM: begin
            if (cnt == WARM_LAST) begin
              state <= ST_KS;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          ST_KS: begin
            if (final_hs) begin
              state    <= ST_IDLE;
              cnt      <= '0;
              busy     <= 1'b0;
              ks_valid <= 1'b0;
              done     <= 1'b1;
            end else if (hs) begin
              cnt      <= cnt + CNT_ONE;
              ks_bit   <= ks_next;
              ks_valid <= 1'b1;
            end else if (!ks_valid) begin
              // First bit of the run: nothing to accept yet.
              ks_bit   <= ks_next;
              ks_valid <= 1'b1;
            end
          end
          default: begin
            state <= ST_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.busy     = busy;
  assign bus.ks_bit   = ks_bit;
  assign bus.ks_valid = ks_valid;
  assign bus.done     = done;
endmodule

// File: tb/tb_a5_keystream_gen.sv
// tb_a5_keystream_gen
// Scoreboard bench for a5_keystream_gen: a bit-level A5/1 model fills the
// expected-bit queue at each start; a negedge monitor pops and compares on
// every accepted handshake.
module tb_a5_keystream_gen;
  localparam logic [63:0] REF_KEY   = 64'hEFCDAB8967452312;
  localparam logic [21:0] REF_FRAME = 22'h134;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  a5_keystream_gen_if bus ();
  a5_keystream_gen dut (.clk(clk), .reset(reset), .bus(bus));

  int   n_tests = 0;
  int   n_fail  = 0;
  logic exp_q[$];
  logic got_q[$];
  int   hs_cnt   = 0;
  int   done_cnt = 0;
  logic rand_mode = 1'b0;
  logic prev_stall = 1'b0;
  logic prev_bit   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Independent A5/1 reference: explicit tap lists, key then frame, warm-up, keystream.
  function automatic logic [227:0] a5_model(input logic [63:0] k, input logic [21:0] f);
    logic [18:0] r1;
    logic [21:0] r2;
    logic [22:0] r3;
    logic [227:0] o;
    logic b, m;
    int j;
    r1 = '0; r2 = '0; r3 = '0; o = '0;
    for (int i = 0; i < 86; i++) begin
      j = i - 64;
      b = (i < 64) ? k[i[5:0]] : f[j[4:0]];
      r1 = {r1[17:0], r1[13] ^ r1[16] ^ r1[17] ^ r1[18] ^ b};
      r2 = {r2[20:0], r2[20] ^ r2[21] ^ b};
      r3 = {r3[21:0], r3[7] ^ r3[20] ^ r3[21] ^ r3[22] ^ b};
    end
    for (int i = 0; i < 328; i++) begin
      m = (r1[8] & r2[10]) | (r1[8] & r3[10]) | (r2[10] & r3[10]);
      if (r1[8] == m) r1 = {r1[17:0], r1[13] ^ r1[16] ^ r1[17] ^ r1[18]};
      if (r2[10] == m) r2 = {r2[20:0], r2[20] ^ r2[21]};
      if (r3[10] == m) r3 = {r3[21:0], r3[7] ^ r3[20] ^ r3[21] ^ r3[22]};
      if (i >= 100) begin
        j = i - 100;
        o[j[7:0]] = r1[18] ^ r2[21] ^ r3[22];
      end
    end
    return o;
  endfunction

  // Consumer: always ready, or pseudo-random backpressure.
  always @(posedge clk) begin
    #1;
    bus.ks_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: stall stability, scoreboard compare on handshake, done count.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(bus.ks_valid), 32'd1);
        check("stall_bit", 32'(bus.ks_bit), 32'(prev_bit));
      end
      if (bus.ks_valid && bus.ks_ready) begin
        check("ks_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("ks_bit", 32'(bus.ks_bit), 32'(exp_q.pop_front()));
        got_q.push_back(bus.ks_bit);
        hs_cnt++;
      end
      if (bus.done) done_cnt++;
      prev_stall = bus.ks_valid && !bus.ks_ready;
      prev_bit   = bus.ks_bit;
    end
  end

  task automatic push_model(input logic [63:0] k, input logic [21:0] f);
    logic [227:0] m;
    m = a5_model(k, f);
    for (int i = 0; i < 228; i++) exp_q.push_back(m[i]);
  endtask

  task automatic pulse_start(input logic [63:0] k, input logic [21:0] f);
    @(posedge clk); #1;
    bus.key = k; bus.frame = f; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("busy_rise", 32'(bus.busy), 32'd1);
  endtask

  task automatic do_run(input logic [63:0] k, input logic [21:0] f,
                        input bit extra_start, input bit check_ref);
    int lat, guard, base_hs, base_done, base_got;
    logic [15:0] first16;
    push_model(k, f);
    base_hs = hs_cnt; base_done = done_cnt; base_got = got_q.size();
    pulse_start(k, f);
    lat = 0;
    while (1) begin
      @(negedge clk);
      if (bus.ks_valid || lat >= 1000) break;
      @(posedge clk); #1;
      lat++;
      bus.start = (extra_start && lat == 50) ? 1'b1 : 1'b0;
    end
    bus.start = 1'b0;
    check("latency", 32'(lat), 32'd187);
    guard = 0;
    while (!bus.done && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    check("run_in_budget", 32'(guard < 3000), 32'd1);
    check("busy_fall", 32'(bus.busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("done_pulses", 32'(done_cnt - base_done), 32'd1);
    check("handshakes", 32'(hs_cnt - base_hs), 32'd228);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("done_low", 32'(bus.done), 32'd0);
    if (check_ref) begin
      first16 = '0;
      for (int i = 0; i < 16; i++) first16 = {first16[14:0], got_q[base_got + i]};
      check("ref_first16", 32'(first16), 32'h534E);
    end
  endtask

  initial begin
    int guard, base_hs;
    reset = 1'b1;
    bus.start = 1'b0; bus.key = '0; bus.frame = '0;
`ifdef A5_ABORT_EN
    bus.abort = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ks_bit", 32'(bus.ks_bit), 32'd0);
    check("rst_ks_valid", 32'(bus.ks_valid), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    do_run(REF_KEY, REF_FRAME, 1'b0, 1'b1);

    rand_mode = 1'b1;
    do_run(REF_KEY, REF_FRAME, 1'b0, 1'b1);
    rand_mode = 1'b0;

    do_run(REF_KEY, REF_FRAME, 1'b1, 1'b1);

    // Reset in the middle of the keystream phase.
    push_model(REF_KEY, REF_FRAME);
    base_hs = hs_cnt;
    pulse_start(REF_KEY, REF_FRAME);
    guard = 0;
    while (hs_cnt - base_hs < 100 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check("reach_bit100", 32'(guard < 1000), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_ks_bit", 32'(bus.ks_bit), 32'd0);
    check("midrst_ks_valid", 32'(bus.ks_valid), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    repeat (2) @(posedge clk);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    do_run(REF_KEY, REF_FRAME, 1'b0, 1'b1);

    do_run(64'h0, 22'h0, 1'b0, 1'b0);

`ifdef A5_ABORT_EN
    begin
      int base_done;
      base_hs = hs_cnt; base_done = done_cnt;
      pulse_start(REF_KEY, REF_FRAME);
      repeat (119) @(posedge clk);
      #1 bus.abort = 1'b1;
      @(posedge clk);
      #1 bus.abort = 1'b0;
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_ks_valid", 32'(bus.ks_valid), 32'd0);
      repeat (300) @(posedge clk);
      #1;
      check("abort_no_done", 32'(done_cnt - base_done), 32'd0);
      check("abort_no_hs", 32'(hs_cnt - base_hs), 32'd0);
      do_run(REF_KEY, REF_FRAME, 1'b0, 1'b1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
